// File: rtl/prog_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : prog_mem_pkg
// Brief  : Shared constants and types for the program memory / boot loader.
// Rev    : 1.0
// ============================================================================
package prog_mem_pkg;

  localparam logic [31:0] c_nop_instr = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2
  } load_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } fetch_rsp_t;

endpackage
`default_nettype wire

// File: rtl/prog_mem_array.sv
`default_nettype none
// ============================================================================
// Module : prog_mem_array
// Brief  : DEPTHx32 RAM, one synchronous read and one synchronous write port.
// Rev    : 1.0
// ============================================================================
module prog_mem_array #(
  parameter  int          DEPTH     = 256,
  parameter  logic [31:0] INIT_WORD = 32'h0000_0013,
  localparam int          AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata
);

  // Words are stored XORed with INIT_WORD, so a zero power-up RAM reads back
  // as INIT_WORD without needing an init file.
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata ^ INIT_WORD;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata ^ INIT_WORD;

endmodule
`default_nettype wire

// File: rtl/program_memory_loader.sv
`default_nettype none
// ============================================================================
// Module : program_memory_loader
// Brief  : Instruction fetch port plus byte-serial little-endian boot loader.
// Rev    : 1.0
// ============================================================================
module program_memory_loader
  import prog_mem_pkg::*;
#(
  parameter  int          DEPTH     = 256,
  parameter  logic [31:0] NOP_INSTR = c_nop_instr,
  localparam int          AW        = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_err,
  input  logic        load_start,
  input  logic [7:0]  load_byte,
  input  logic        load_byte_valid,
  output logic        load_byte_ready,
  input  logic        load_done,
  output logic        loading,
  output logic [AW:0] load_words,
  output logic        load_overflow
);

  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  load_state_e r_state;
  load_state_e w_state_nxt;
  logic        w_enter_load;

  logic [1:0]  r_idx;
  logic [23:0] r_buf;
  logic [AW:0] r_ptr;
  logic        r_ovf;

  logic        w_full;
  logic        w_byte_acc;
  logic        w_byte_store;
  logic        w_word_done;
  logic        w_partial_nxt;
  logic        w_we;
  logic [31:0] w_wdata;

  logic        w_fetch_acc;
  logic        w_addr_err;
  logic [31:0] w_rd_data;
  logic        r_fetch_valid;
  logic        r_fetch_err;
  logic [31:0] r_instr_hold;
  fetch_rsp_t  w_rsp;

  assign w_full       = (r_ptr == c_depth);
  assign w_byte_acc   = (r_state == LOAD) && load_byte_valid && !load_start;
  assign w_byte_store = w_byte_acc && !w_full;
  assign w_word_done  = w_byte_store && (r_idx == 2'd3);
  // Byte index after this cycle's byte (if any) has been consumed.
  assign w_partial_nxt = w_byte_store ? (r_idx != 2'd3) : (r_idx != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_enter_load    = 1'b0;
    fetch_ready     = 1'b0;
    load_byte_ready = 1'b0;
    loading         = 1'b0;
    case (r_state)
      RUN: begin
        fetch_ready = 1'b1;
        if (load_start) begin
          w_state_nxt  = LOAD;
          w_enter_load = 1'b1;
        end
      end
      LOAD: begin
        load_byte_ready = 1'b1;
        loading         = 1'b1;
        if (load_start) begin
          w_enter_load = 1'b1;
        end else if (load_done) begin
          w_state_nxt = w_partial_nxt ? PAD : RUN;
        end
      end
      PAD: begin
        loading = 1'b1;
        if (load_start) begin
          w_state_nxt  = LOAD;
          w_enter_load = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_we    = w_word_done || (r_state == PAD);
  assign w_wdata = (r_state == PAD) ? {8'h00, r_buf} : {load_byte, r_buf};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= 2'd0;
      r_buf <= 24'd0;
      r_ptr <= '0;
      r_ovf <= 1'b0;
    end else if (w_enter_load) begin
      r_idx <= 2'd0;
      r_buf <= 24'd0;
      r_ptr <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_byte_acc && w_full) begin
        r_ovf <= 1'b1;
      end
      // Buffer is cleared after every write so a padded word has zero upper bytes.
      if (w_we) begin
        r_ptr <= r_ptr + 1'b1;
        r_idx <= 2'd0;
        r_buf <= 24'd0;
      end else if (w_byte_store) begin
        r_idx <= r_idx + 1'b1;
        case (r_idx)
          2'd0:    r_buf[7:0]   <= load_byte;
          2'd1:    r_buf[15:8]  <= load_byte;
          default: r_buf[23:16] <= load_byte;
        endcase
      end
    end
  end

  assign load_words    = r_ptr;
  assign load_overflow = r_ovf;

  assign w_fetch_acc = fetch_req && fetch_ready;
  assign w_addr_err  = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);

  prog_mem_array #(
    .DEPTH     (DEPTH),
    .INIT_WORD (NOP_INSTR)
  ) u_mem (
    .clk     (clk),
    .i_re    (w_fetch_acc),
    .i_raddr (fetch_addr[AW+1:2]),
    .o_rdata (w_rd_data),
    .i_we    (w_we),
    .i_waddr (r_ptr[AW-1:0]),
    .i_wdata (w_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_instr_hold  <= NOP_INSTR;
    end else begin
      r_fetch_valid <= w_fetch_acc;
      r_fetch_err   <= w_fetch_acc && w_addr_err;
      r_instr_hold  <= w_rsp.instr;
    end
  end

  always_comb begin
    w_rsp.instr = r_instr_hold;
    w_rsp.err   = 1'b0;
    if (r_fetch_valid) begin
      w_rsp.instr = r_fetch_err ? NOP_INSTR : w_rd_data;
      w_rsp.err   = r_fetch_err;
    end
  end

  assign fetch_valid = r_fetch_valid;
  assign fetch_instr = w_rsp.instr;
  assign fetch_err   = w_rsp.err;

endmodule
`default_nettype wire

// File: tb/tb_program_memory_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_program_memory_loader
// Brief  : Scoreboard bench for program_memory_loader with a word-level model.
// Rev    : 1.0
// ============================================================================
module tb_program_memory_loader;

  localparam int          DEPTH = 8;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_err;
  logic        load_start = 1'b0;
  logic [7:0]  load_byte = 8'd0;
  logic        load_byte_valid = 1'b0;
  logic        load_byte_ready;
  logic        load_done = 1'b0;
  logic        loading;
  logic [AW:0] load_words;
  logic        load_overflow;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem[DEPTH];
  logic [7:0]  sess_bytes[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_instr = NOP;

  program_memory_loader #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .fetch_instr     (fetch_instr),
    .fetch_err       (fetch_err),
    .load_start      (load_start),
    .load_byte       (load_byte),
    .load_byte_valid (load_byte_valid),
    .load_byte_ready (load_byte_ready),
    .load_done       (load_done),
    .loading         (loading),
    .load_words      (load_words),
    .load_overflow   (load_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; queues the expected response if the port is ready.
  task automatic issue_fetch(input logic [31:0] a);
    exp_t e;
    int   widx;
    fetch_req  = 1'b1;
    fetch_addr = a;
    if (fetch_ready) begin
      widx = int'(a >> 2);
      if (a[1:0] != 2'b00 || widx >= DEPTH) begin
        e.instr = NOP;
        e.err   = 1'b1;
      end else begin
        e.instr = model_mem[widx];
        e.err   = 1'b0;
      end
      e.due = cyc + 1;
      sb.push_back(e);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int          s;
    logic [31:0] a;
    s = int'($urandom_range(0, 9));
    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (s == 0) a = a | 32'($urandom_range(1, 3));
    else if (s == 1) a = $urandom;
    return a;
  endfunction

  task automatic fetch_two(input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk); issue_fetch(a0);
    @(negedge clk); issue_fetch(a1);
    @(negedge clk); fetch_req = 1'b0;
  endtask

  task automatic fetch_all_words();
    for (int w = 0; w < DEPTH; w++) begin
      @(negedge clk); issue_fetch(32'(w) << 2);
    end
    @(negedge clk); fetch_req = 1'b0;
  endtask

  task automatic fetch_random(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) fetch_req = 1'b0;
      else issue_fetch(rand_addr());
    end
    @(negedge clk); fetch_req = 1'b0;
  endtask

  task automatic fill_random(input int n);
    sess_bytes.delete();
    for (int i = 0; i < n; i++) sess_bytes.push_back(8'($urandom));
  endtask

  // One complete load session of the bytes in sess_bytes, then model update.
  task automatic run_session(input bit done_last, input bit try_fetch, input bit overlap);
    int n, nw;
    bit partial;
    logic [31:0] word;
    n = sess_bytes.size();
    @(negedge clk);
    load_start = 1'b1;
    if (overlap) issue_fetch(rand_addr());
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = try_fetch;
    fetch_addr = 32'd0;
    check("start_loading", 32'(loading), 32'd1);
    check("start_words", 32'(load_words), 32'd0);
    check("start_overflow", 32'(load_overflow), 32'd0);
    check("load_fetch_ready", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        load_byte_valid = 1'b0;
        @(negedge clk);
      end
      load_byte       = sess_bytes[i];
      load_byte_valid = 1'b1;
      load_done       = done_last && (i == n - 1);
      check("byte_ready", 32'(load_byte_ready), 32'd1);
      @(negedge clk);
    end
    load_byte_valid = 1'b0;
    if (!(done_last && n > 0)) begin
      load_done = 1'b1;
      @(negedge clk);
    end
    load_done = 1'b0;
    fetch_req = 1'b0;

    partial = (n < 4 * DEPTH) && (n % 4 != 0);
    check("pad_cycle", 32'(loading), 32'(partial));
    if (partial) begin
      @(negedge clk);
      check("after_pad", 32'(loading), 32'd0);
    end
    nw = (n + 3) / 4;
    if (nw > DEPTH) nw = DEPTH;
    check("load_words", 32'(load_words), 32'(nw));
    check("load_overflow", 32'(load_overflow), 32'(n > 4 * DEPTH));
    for (int w = 0; w < nw; w++) begin
      word = 32'd0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) word = word | (32'(sess_bytes[4 * w + k]) << (8 * k));
      end
      model_mem[w] = word;
    end
  endtask

  task automatic reset_mid_load();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    fill_random(6);
    for (int i = 0; i < 6; i++) begin
      load_byte = sess_bytes[i]; load_byte_valid = 1'b1;
      @(negedge clk);
    end
    load_byte_valid = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_words", 32'(load_words), 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    check("rst_byte_ready", 32'(load_byte_ready), 32'd0);
    #2 reset = 1'b0;
    model_mem[0] = {sess_bytes[3], sess_bytes[2], sess_bytes[1], sess_bytes[0]};
  endtask

  // Monitor: every falling edge either pops an expected response or checks idle hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_instr = NOP;
      end else if (fetch_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(fetch_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("fetch_instr", fetch_instr, e.instr);
          check("fetch_err", 32'(fetch_err), 32'(e.err));
          check("fetch_latency", 32'(cyc), 32'(e.due));
          last_instr = e.instr;
        end
      end else begin
        check("hold_instr", fetch_instr, last_instr);
        check("idle_err", 32'(fetch_err), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int w = 0; w < DEPTH; w++) model_mem[w] = NOP;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_instr", fetch_instr, NOP);
    check("rst_load_words", 32'(load_words), 32'd0);
    check("rst_overflow", 32'(load_overflow), 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);

    fetch_two(32'h0, 32'h4);

    sess_bytes = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    run_session(1'b0, 1'b0, 1'b0);
    fetch_two(32'h0, 32'h4);

    sess_bytes = '{8'hAA, 8'hBB, 8'hCC};
    run_session(1'b0, 1'b1, 1'b0);
    fetch_two(32'h0, 32'h4);

    fetch_two(32'h2, 32'(4 * DEPTH));

    fill_random(4 * DEPTH + 2);
    run_session(1'b1, 1'b0, 1'b1);
    fetch_all_words();

    for (int s = 0; s < 6; s++) begin
      fill_random(int'($urandom_range(0, 4 * DEPTH + 3)));
      run_session(1'($urandom), 1'($urandom), 1'($urandom));
      fetch_random(12);
    end

    reset_mid_load();
    fetch_all_words();
    fetch_random(16);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
